// File: rtl/idct_pkg.sv
// Shared widths, Q1.12 cosine constants, FSM states and output rounding for the 8-point IDCT.
package idct_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned ACC_W = N + 16;
  localparam int unsigned FRAC  = 12;

  localparam logic signed [ACC_W-1:0] K0 = 1448;
  localparam logic signed [ACC_W-1:0] K1 = 2009;
  localparam logic signed [ACC_W-1:0] K2 = 1892;
  localparam logic signed [ACC_W-1:0] K3 = 1703;
  localparam logic signed [ACC_W-1:0] K4 = K0;
  localparam logic signed [ACC_W-1:0] K5 = 1138;
  localparam logic signed [ACC_W-1:0] K6 = 784;
  localparam logic signed [ACC_W-1:0] K7 = 400;

  localparam logic signed [ACC_W-1:0] RoundC = 1 << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SatMax = (1 << (N - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SatMin = -(1 << (N - 1));

  typedef enum logic [1:0] {StLoad, StCalc1, StCalc2, StOut} state_e;

  // Round half up, drop the fraction, clip to the signed N-bit range.
  function automatic logic signed [N-1:0] round_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = (v + RoundC) >>> FRAC;
    if (r > SatMax) begin
      return SatMax[N-1:0];
    end else if (r < SatMin) begin
      return SatMin[N-1:0];
    end
    return r[N-1:0];
  endfunction

endpackage

// File: rtl/idct_butterfly4.sv
// Combinational output butterfly: x[n] = e[n] + o[n], x[7-n] = e[n] - o[n], rounded and clipped.
module idct_butterfly4
  import idct_pkg::*;
(
  input  logic [4*ACC_W-1:0] even,
  input  logic [4*ACC_W-1:0] odd,
  output logic [8*N-1:0]     samples
);

  for (genvar g = 0; g < 4; g++) begin : g_pair
    logic signed [ACC_W-1:0] e_v;
    logic signed [ACC_W-1:0] o_v;

    assign e_v = even[g*ACC_W +: ACC_W];
    assign o_v = odd[g*ACC_W +: ACC_W];

    assign samples[g*N +: N]     = round_sat(e_v + o_v);
    assign samples[(7-g)*N +: N] = round_sat(e_v - o_v);
  end

endmodule

// File: rtl/idct1d.sv
// 8-point 1-D inverse DCT: serial coefficient load, two compute cycles, serial sample output.
module idct1d
  import idct_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;

  logic signed [N-1:0]     coef_q [8];
  logic signed [ACC_W-1:0] c      [8];
  logic signed [ACC_W-1:0] even_d [4];
  logic signed [ACC_W-1:0] odd_d  [4];
  logic signed [ACC_W-1:0] even_q [4];
  logic signed [ACC_W-1:0] odd_q  [4];

  logic [4*ACC_W-1:0] even_flat, odd_flat;
  logic [8*N-1:0]     bfly_out, samp_q;
  logic               in_hs, out_hs;

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StOut);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign out_last  = out_valid && (idx_q == 3'd7);
  assign out_data  = out_valid ? samp_q[idx_q*N +: N] : '0;

  // Full-precision partial sums; cosine signs follow cos((2n+1)k*pi/16).
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      c[i] = ACC_W'(coef_q[i]);
    end
    even_d[0] = K0*c[0] + K2*c[2] + K4*c[4] + K6*c[6];
    even_d[1] = K0*c[0] + K6*c[2] - K4*c[4] - K2*c[6];
    even_d[2] = K0*c[0] - K6*c[2] - K4*c[4] + K2*c[6];
    even_d[3] = K0*c[0] - K2*c[2] + K4*c[4] - K6*c[6];
    odd_d[0]  = K1*c[1] + K3*c[3] + K5*c[5] + K7*c[7];
    odd_d[1]  = K3*c[1] - K7*c[3] - K1*c[5] - K5*c[7];
    odd_d[2]  = K5*c[1] - K1*c[3] + K7*c[5] + K3*c[7];
    odd_d[3]  = K7*c[1] - K5*c[3] + K3*c[5] - K1*c[7];
  end

  assign even_flat = {even_q[3], even_q[2], even_q[1], even_q[0]};
  assign odd_flat  = {odd_q[3], odd_q[2], odd_q[1], odd_q[0]};

  idct_butterfly4 u_butterfly (
    .even    (even_flat),
    .odd     (odd_flat),
    .samples (bfly_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      StLoad: begin
        if (in_hs) begin
          if (cnt_q == 3'd7) begin
            cnt_d   = '0;
            state_d = StCalc1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StCalc1: state_d = StCalc2;
      StCalc2: state_d = StOut;
      StOut: begin
        if (out_hs) begin
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = StLoad;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath registers need no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      coef_q[cnt_q] <= in_data;
    end
    if (state_q == StCalc1) begin
      even_q <= even_d;
      odd_q  <= odd_d;
    end
    if (state_q == StCalc2) begin
      samp_q <= bfly_out;
    end
  end

endmodule

// File: tb/tb_idct1d.sv
// Randomised bench for idct1d against a cosine-derived fixed-point model and a real-valued model.
module tb_idct1d;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int kmat [8][8];
  real pi = 3.14159265358979;

  idct1d dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit reached, expected self-termination");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    int d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi($floor(r + 0.5));
    return -$rtoi($floor(-r + 0.5));
  endfunction

  function automatic real ck(input int k);
    return (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
  endfunction

  // Bit-exact model: Q1.12 weights straight from the cosine formula, exact integer sum.
  task automatic ref_idct(input int x[8], output int y[8]);
    for (int n = 0; n < 8; n++) begin
      longint acc;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(kmat[n][k]) * longint'(x[k]);
      acc = (acc + 2048) >>> 12;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      y[n] = int'(acc);
    end
  endtask

  task automatic real_idct(input int x[8], output real y[8]);
    for (int n = 0; n < 8; n++) begin
      y[n] = 0.0;
      for (int k = 0; k < 8; k++) y[n] += ck(k) * x[k] * $cos((2 * n + 1) * k * pi / 16.0);
    end
  endtask

  task automatic real_fdct(input int s[8], output int x[8]);
    for (int k = 0; k < 8; k++) begin
      real acc;
      acc = 0.0;
      for (int n = 0; n < 8; n++) acc += s[n] * $cos((2 * n + 1) * k * pi / 16.0);
      x[k] = rnd(ck(k) * acc);
    end
  endtask

  task automatic send_frame(input int x[8], input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      bit hs;
      int tries;
      hs = 1'b0;
      tries = 0;
      while (!hs && tries < 50) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = 16'(x[i]);
        @(negedge clk);
        hs = in_valid && in_ready;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!hs) check("in_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic recv_frame(input int mode, output int y[8]);
    int idx, lat, held;
    bit seen, pend;
    idx = 0; lat = 0; held = 0; seen = 0; pend = 0;
    for (int n = 0; n < 8; n++) y[n] = 0;
    for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (!seen) lat++;
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", lat, 3);
        end
        if (pend) check("hold", int'($signed(out_data)), held);
        check("in_ready_busy", int'(in_ready), 0);
        if (out_ready) begin
          y[idx] = int'($signed(out_data));
          check("out_last", int'(out_last), int'(idx == 7));
          idx++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = int'($signed(out_data));
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (idx < 8) begin
      check("out_timeout", idx, 8);
    end else begin
      @(negedge clk);
      check("in_ready_after", int'(in_ready), 1);
      check("idle_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int x[8], input bit gaps, input int mode, input bit junk,
                           output int y[8]);
    int exp[8];
    send_frame(x, 8, gaps);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 16'h7fff;
    end
    recv_frame(mode, y);
    ref_idct(x, exp);
    for (int n = 0; n < 8; n++) check($sformatf("model_x%0d", n), y[n], exp[n]);
  endtask

  initial begin
    int x[8], y[8], s[8], odd_exp[8];
    real yr[8];

    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++)
        kmat[n][k] = rnd(4096.0 * ck(k) * $cos((2 * n + 1) * k * pi / 16.0));

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;

    x = '{256, 0, 0, 0, 0, 0, 0, 0};
    run_frame(x, 1'b0, 0, 1'b0, y);
    for (int n = 0; n < 8; n++) check("dc", y[n], 91);

    x = '{0, 1000, 0, 0, 0, 0, 0, 0};
    odd_exp = '{490, 416, 278, 98, -98, -278, -416, -490};
    run_frame(x, 1'b0, 0, 1'b0, y);
    for (int n = 0; n < 8; n++) check("odd_x1", y[n], odd_exp[n]);

    x = '{32767, 0, 32767, 0, 0, 0, 0, 0};
    run_frame(x, 1'b0, 0, 1'b0, y);
    x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    run_frame(x, 1'b0, 0, 1'b0, y);
    check("sat_pos", y[0], 32767);
    x = '{-32768, 0, -32768, 0, -32768, 0, -32768, 0};
    run_frame(x, 1'b0, 0, 1'b0, y);
    check("sat_neg", y[0], -32768);

    for (int i = 0; i < 8; i++) x[i] = $urandom_range(0, 4000) - 2000;
    run_frame(x, 1'b0, 1, 1'b1, y);

    for (int i = 0; i < 8; i++) x[i] = $urandom_range(0, 65535) - 32768;
    send_frame(x, 5, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    x = '{256, 0, 0, 0, 0, 0, 0, 0};
    run_frame(x, 1'b0, 0, 1'b0, y);
    for (int n = 0; n < 8; n++) check("mid_rst_dc", y[n], 91);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 8; i++) x[i] = $urandom_range(0, 65535) - 32768;
      run_frame(x, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), y);
    end

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++) s[i] = $urandom_range(0, 511) - 256;
      real_fdct(s, x);
      run_frame(x, 1'b0, 0, 1'b0, y);
      real_idct(x, yr);
      for (int n = 0; n < 8; n++) begin
        check("roundtrip", y[n], s[n], 2);
        check("real_model", y[n], rnd(yr[n]), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
